mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 109 ++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX payload, extracts load data from the synchronous SRAM,
// and holds the read data while WB stalls so a stalled load keeps its result.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_to_ms_bus,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [38:0] ms_to_ds_bus
);

  localparam int unsigned EsToMsBusWd = 74;
  localparam int unsigned MsToWsBusWd = 70;

  logic                   ms_valid_q, ms_valid_d;
  logic [EsToMsBusWd-1:0] payload_q, payload_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [31:0]            rdata_hold_q, rdata_hold_d;

  logic [2:0]  ld_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  addr;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] final_result;

  assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = payload_q;
  assign addr = alu_result[1:0];

  // Ready-go is constant, so the stage can take a new instruction whenever its slot frees up.
  assign ms_allowin     = !ms_valid_q || ws_allowin;
  assign ms_to_ws_valid = ms_valid_q;

  always_comb begin
    ms_valid_d   = ms_allowin ? es_to_ms_valid : ms_valid_q;
    payload_d    = (es_to_ms_valid && ms_allowin) ? es_to_ms_bus : payload_q;
    hold_vld_d   = hold_vld_q;
    rdata_hold_d = rdata_hold_q;
    // SRAM data is only valid in the first cycle, so capture it when WB stalls a load.
    if (ms_allowin) begin
      hold_vld_d = 1'b0;
    end else if (ms_valid_q && res_from_mem && !hold_vld_q && !ws_allowin) begin
      hold_vld_d   = 1'b1;
      rdata_hold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      payload_q    <= '0;
      hold_vld_q   <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      payload_q    <= payload_d;
      hold_vld_q   <= hold_vld_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign ld_data = hold_vld_q ? rdata_hold_q : data_sram_rdata;

  always_comb begin
    ld_byte = ld_data[7:0];
    unique case (addr)
      2'b00: ld_byte = ld_data[7:0];
      2'b01: ld_byte = ld_data[15:8];
      2'b10: ld_byte = ld_data[23:16];
      2'b11: ld_byte = ld_data[31:24];
    endcase
  end

  assign ld_half = addr[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    ld_value = ld_data;
    case (ld_op)
      3'b001:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_value = {24'd0, ld_byte};
      3'b110:  ld_value = {16'd0, ld_half};
      default: ld_value = ld_data;
    endcase
  end

  assign final_result = res_from_mem ? ld_value : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  assign ms_to_ds_bus = {ms_valid_q && gr_we && (dest != 5'd0),
                         ms_valid_q && res_from_mem,
                         dest,
                         final_result};

  logic [MsToWsBusWd-1:0] unused_width_chk;
  assign unused_width_chk = ms_to_ws_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load/stall cases, then random traffic against a
// transaction-level model, then an asynchronous reset in the middle of a stalled load.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_ds_bus;

  mem_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .ws_allowin     (ws_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .data_sram_rdata(data_sram_rdata),
    .ms_to_ds_bus   (ms_to_ds_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        res;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] word;
    bit          stall;
  } item_t;

  typedef struct {
    logic [69:0] ws;
    logic [38:0] ds;
  } exp_t;

  exp_t  sb[$];
  item_t dir[$];
  item_t pend;
  bit    pend_acc = 1'b0;
  int    stall_cnt = 0;
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_load(logic [2:0] op, logic [1:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'h0000_00ff;
    h = (w >> (16 * a[1])) & 32'h0000_ffff;
    case (op)
      3'b001:  return (b > 32'h7f) ? (b | 32'hffff_ff00) : b;
      3'b010:  return (h > 32'h7fff) ? (h | 32'hffff_0000) : h;
      3'b101:  return b;
      3'b110:  return h;
      default: return w;
    endcase
  endfunction

  function automatic exp_t mk(item_t it);
    exp_t e;
    logic [31:0] fr;
    fr   = it.res ? ref_load(it.op, it.alu[1:0], it.word) : it.alu;
    e.ws = {it.we, it.dest, fr, it.pc};
    e.ds = {it.we && (it.dest != 5'd0), it.res, it.dest, fr};
    return e;
  endfunction

  function automatic item_t mk_item(logic [2:0] op, logic res, logic [4:0] dest,
                                    logic [31:0] alu, logic [31:0] word, bit stall);
    item_t it;
    it.op = op; it.res = res; it.we = 1'b1; it.dest = dest; it.alu = alu;
    it.pc = $urandom; it.word = word; it.stall = stall;
    return it;
  endfunction

  function automatic item_t rand_item();
    item_t it;
    it.op    = 3'($urandom_range(0, 7));
    it.res   = 1'($urandom);
    it.we    = 1'($urandom);
    it.dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    it.alu   = $urandom;
    it.pc    = $urandom;
    it.word  = $urandom;
    it.stall = 1'b0;
    return it;
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input bit v, input item_t it, input bit w, output bit acc);
    @(posedge clk);
    #1;
    if (pend_acc) begin
      sb.push_back(mk(pend));
      data_sram_rdata = pend.word;
      if (pend.stall) stall_cnt = 3;
    end else begin
      data_sram_rdata = $urandom;
    end
    if (stall_cnt > 0) begin
      w = 1'b0;
      stall_cnt--;
    end
    es_to_ms_valid = v;
    es_to_ms_bus   = {it.op, it.res, it.we, it.dest, it.alu, it.pc};
    ws_allowin     = w;
    acc            = v && ((sb.size() == 0) || w);
    pend           = it;
    pend_acc       = acc;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ms_allowin", 70'(ms_allowin), 70'((sb.size() == 0) || ws_allowin));
      chk("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(sb.size() != 0));
      if (sb.size() == 0) begin
        chk("fwd_ctrl_idle", 70'(ms_to_ds_bus[38:37]), 70'd0);
      end else begin
        chk("ms_to_ds_bus", 70'(ms_to_ds_bus), 70'(sb[0].ds));
        if (ws_allowin) begin
          chk("ms_to_ws_bus", ms_to_ws_bus, sb[0].ws);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bit    acc;
    item_t it;
    resetn          = 1'b0;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    ws_allowin      = 1'b0;
    data_sram_rdata = '0;
    #12;
    chk("rst_ms_to_ws_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("rst_ms_allowin", 70'(ms_allowin), 70'd1);
    chk("rst_fwd_ctrl", 70'(ms_to_ds_bus[38:37]), 70'd0);
    chk("rst_ms_to_ws_bus", ms_to_ws_bus, 70'd0);

    for (int i = 0; i < 6; i++) dir.push_back(mk_item(3'b000, 1'b0, 5'd3, 32'h1234_5678, 0, 0));
    dir.push_back(mk_item(3'b001, 1'b1, 5'd4, 32'h1000_0003, 32'h8012_3456, 0));
    dir.push_back(mk_item(3'b101, 1'b1, 5'd4, 32'h1000_0003, 32'h80ab_cdef, 0));
    dir.push_back(mk_item(3'b110, 1'b1, 5'd6, 32'h1000_0002, 32'hbeef_0000, 0));
    dir.push_back(mk_item(3'b010, 1'b1, 5'd6, 32'h1000_0002, 32'hbeef_0000, 0));
    dir.push_back(mk_item(3'b000, 1'b1, 5'd7, 32'h1000_0000, 32'hcafe_f00d, 1));
    dir.push_back(mk_item(3'b000, 1'b1, 5'd5, 32'h1000_0004, 32'h1357_9bdf, 1));
    dir.push_back(mk_item(3'b000, 1'b1, 5'd0, 32'h1000_0008, 32'h2468_ace0, 0));

    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    for (int c = 0; c < 200 && dir.size() != 0; c++) begin
      step(1'b1, dir[0], 1'b1, acc);
      if (acc) void'(dir.pop_front());
    end
    for (int c = 0; c < 600; c++) begin
      it = rand_item();
      step($urandom_range(0, 3) != 0, it, $urandom_range(0, 9) > 2, acc);
    end
    it = rand_item();
    for (int c = 0; c < 6; c++) step(1'b0, it, 1'b1, acc);
    @(negedge clk);
    chk("drain_empty", 70'(sb.size()), 70'd0);
    mon_en = 1'b0;

    // Stalled load, then reset while the hold register is live.
    @(posedge clk); #1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = {3'b000, 1'b1, 1'b1, 5'd5, 32'h2000_0000, 32'h0000_4000};
    ws_allowin     = 1'b0;
    @(posedge clk); #1;
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    data_sram_rdata = 32'hdead_dead;
    @(negedge clk);
    chk("stall_hold_vld", 70'(dut.hold_vld_q), 70'd1);
    chk("stall_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("stall_allowin", 70'(ms_allowin), 70'd0);
    chk("stall_fwd", 70'(ms_to_ds_bus), 70'({1'b1, 1'b1, 5'd5, 32'h1111_2222}));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("async_rst_hold_vld", 70'(dut.hold_vld_q), 70'd0);
    chk("async_rst_allowin", 70'(ms_allowin), 70'd1);
    chk("async_rst_fwd_ctrl", 70'(ms_to_ds_bus[38:37]), 70'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_allowin", 70'(ms_allowin), 70'd1);
    chk("post_rst_valid", 70'(ms_to_ws_valid), 70'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
